// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter. It caps bursts at MAXBURST owned cycles and muxes the
// address phase and the delayed data phase. Optional macro ARB_LOCK_EN honours HLOCK.
module ahb_bus_arbiter #(
  parameter int NM       = 4,
  parameter int MAXBURST = 4,
  parameter int MW       = (NM > 2) ? $clog2(NM) : 1
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [NM-1:0]    HBUSREQ,
  input  logic [NM-1:0]    HLOCK,
  input  logic [NM*32-1:0] HADDR_M,
  input  logic [NM-1:0]    HWRITE_M,
  input  logic [NM*32-1:0] HWDATA_M,
  output logic [NM-1:0]    HGRANT,
  output logic [MW-1:0]    HMASTER,
  output logic [MW-1:0]    HMASTERDEL,
  output logic [31:0]      HADDR,
  output logic             HWRITE,
  output logic [31:0]      HWDATA
);

  typedef enum logic [0:0] {PARK = 1'b0, OWN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] hmaster_q, hmaster_d;
  logic [MW-1:0] hmasterdel_q;
  logic [NM-1:0] hgrant_q, hgrant_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          locked_q, locked_d;

  logic          found_s;
  logic [MW-1:0] cand_s;
  logic          owner_req_s;
  logic          others_req_s;
  logic [3:0]    cnt_inc_s;
  int            rr_base_s;
  int            rr_idx_s;

`ifndef ARB_LOCK_EN
  logic          hlock_unused_s;
  assign hlock_unused_s = ^HLOCK;
`endif

  // Round-robin search for the first requester; parked search starts at master 0.
  always_comb begin
    found_s   = 1'b0;
    cand_s    = '0;
    rr_idx_s  = 0;
    rr_base_s = (state_q == OWN) ? int'(hmaster_q) + 1 : 0;
    for (int i = 0; i < NM; i++) begin
      rr_idx_s = (rr_base_s + i) % NM;
      if (!found_s && HBUSREQ[rr_idx_s]) begin
        found_s = 1'b1;
        cand_s  = MW'(rr_idx_s);
      end else begin
        cand_s  = cand_s;
      end
    end
  end

  assign owner_req_s  = HBUSREQ[hmaster_q];
  assign others_req_s = |(HBUSREQ & ~hgrant_q);
  assign cnt_inc_s    = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

  // Next-owner selection: lock hold, capped burst hold, round-robin handover, park.
  always_comb begin
    state_d   = state_q;
    hmaster_d = hmaster_q;
    cnt_d     = cnt_q;
    case (state_q)
      OWN: begin
        if (locked_q && owner_req_s) begin
          cnt_d = cnt_inc_s;
        end else if (owner_req_s && ((cnt_q < 4'(MAXBURST - 1)) || !others_req_s)) begin
          cnt_d = cnt_inc_s;
        end else if (found_s) begin
          hmaster_d = cand_s;
          cnt_d     = 4'd0;
        end else begin
          state_d   = PARK;
          hmaster_d = '0;
          cnt_d     = 4'd0;
        end
      end
      PARK: begin
        if (found_s) begin
          state_d   = OWN;
          hmaster_d = cand_s;
          cnt_d     = 4'd0;
        end else begin
          state_d   = PARK;
          hmaster_d = '0;
          cnt_d     = 4'd0;
        end
      end
      default: begin
        state_d   = PARK;
        hmaster_d = '0;
        cnt_d     = 4'd0;
      end
    endcase
  end

  // Lock follows the (new) owner's HLOCK and drops whenever the owner releases the bus.
  always_comb begin
`ifdef ARB_LOCK_EN
    if (state_d == OWN) begin
      locked_d = HLOCK[hmaster_d];
    end else begin
      locked_d = 1'b0;
    end
`else
    locked_d = 1'b0;
`endif
  end

  // One-hot grant decoded from the next owner index.
  always_comb begin
    hgrant_d = '0;
    for (int i = 0; i < NM; i++) begin
      hgrant_d[i] = (hmaster_d == MW'(i));
    end
  end

  // Arbiter state registers; HMASTERDEL trails HMASTER by one edge, parked or not.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= PARK;
      hmaster_q    <= '0;
      hmasterdel_q <= '0;
      hgrant_q     <= NM'(1);
      cnt_q        <= 4'd0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hmaster_q    <= hmaster_d;
      hmasterdel_q <= hmaster_q;
      hgrant_q     <= hgrant_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
    end
  end

  assign HGRANT     = hgrant_q;
  assign HMASTER    = hmaster_q;
  assign HMASTERDEL = hmasterdel_q;
  assign HADDR      = HADDR_M[{hmaster_q, 5'd0} +: 32];
  assign HWRITE     = HWRITE_M[hmaster_q] & (state_q == OWN);
  assign HWDATA     = HWDATA_M[{hmasterdel_q, 5'd0} +: 32];

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (NM=4, MAXBURST=4); the lock checks follow ARB_LOCK_EN.
module tb_ahb_bus_arbiter;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [3:0]   HBUSREQ;
  logic [3:0]   HLOCK;
  logic [127:0] HADDR_M;
  logic [3:0]   HWRITE_M;
  logic [127:0] HWDATA_M;
  logic [3:0]   HGRANT;
  logic [1:0]   HMASTER;
  logic [1:0]   HMASTERDEL;
  logic [31:0]  HADDR;
  logic         HWRITE;
  logic [31:0]  HWDATA;

  logic [31:0]  addr_c [4];
  logic [31:0]  data_c [4];
  int           n_checks = 0;
  int           n_fail   = 0;

  ahb_bus_arbiter #(.NM(4), .MAXBURST(4), .MW(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HADDR_M(HADDR_M), .HWRITE_M(HWRITE_M), .HWDATA_M(HWDATA_M),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTERDEL(HMASTERDEL),
    .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic [1:0] exp_m;
    for (int i = 0; i < 4; i++) begin
      addr_c[i] = 32'hA000_0000 + 32'(i) * 32'h100;
      data_c[i] = 32'hD000_0000 + 32'(i) * 32'h11;
      HADDR_M[32*i +: 32]  = addr_c[i];
      HWDATA_M[32*i +: 32] = data_c[i];
    end
    HWRITE_M = 4'b1011;
    HLOCK    = 4'b0000;
    HRESET   = 1'b1;
    HBUSREQ  = 4'($urandom);

    // 1: reset values, then stay parked with no requests
    #12;
    check_eq("rst_grant", 32'(HGRANT), 32'd1);
    check_eq("rst_master", 32'(HMASTER), 32'd0);
    check_eq("rst_masterdel", 32'(HMASTERDEL), 32'd0);
    check_eq("rst_hwrite", 32'(HWRITE), 32'd0);
    check_eq("rst_haddr", HADDR, addr_c[0]);
    check_eq("rst_hwdata", HWDATA, data_c[0]);
    @(negedge HCLK);
    HRESET  = 1'b0;
    HBUSREQ = 4'b0000;
    tick();
    tick();
    check_eq("park_grant", 32'(HGRANT), 32'd1);
    check_eq("park_hwrite", 32'(HWRITE), 32'd0);

    // glitch between edges is not granted
    HBUSREQ = 4'b0100;
    #2;
    HBUSREQ = 4'b0000;
    tick();
    check_eq("glitch_master", 32'(HMASTER), 32'd0);
    check_eq("glitch_grant", 32'(HGRANT), 32'd1);

    // 2: single request from master 1, then release to park
    HBUSREQ = 4'b0010;
    tick();
    check_eq("req1_grant", 32'(HGRANT), 32'b0010);
    check_eq("req1_master", 32'(HMASTER), 32'd1);
    check_eq("req1_haddr", HADDR, addr_c[1]);
    check_eq("req1_hwrite", 32'(HWRITE), 32'd1);
    check_eq("req1_masterdel", 32'(HMASTERDEL), 32'd0);
    HBUSREQ = 4'b0000;
    tick();
    check_eq("rel1_master", 32'(HMASTER), 32'd0);
    check_eq("rel1_masterdel", 32'(HMASTERDEL), 32'd1);
    check_eq("rel1_hwdata", HWDATA, data_c[1]);
    check_eq("rel1_hwrite", 32'(HWRITE), 32'd0);
    tick();
    check_eq("rel1_masterdel2", 32'(HMASTERDEL), 32'd0);

    // 3: all request -> four cycles each, wrapping 3 -> 0
    HBUSREQ = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      exp_m = 2'((k / 4) % 4);
      tick();
      check_eq($sformatf("rr_master_%0d", k), 32'(HMASTER), 32'(exp_m));
      check_eq($sformatf("rr_grant_%0d", k), 32'(HGRANT), 32'(4'b0001 << exp_m));
    end
    HBUSREQ = 4'b0000;
    tick();
    tick();
    check_eq("rr_park", 32'(HMASTER), 32'd0);

    // 4: master 2 owns with HLOCK while everyone requests
    HBUSREQ = 4'b0100;
    HLOCK   = 4'b0100;
    tick();
    check_eq("lock_own", 32'(HMASTER), 32'd2);
    HBUSREQ = 4'b1111;
    for (int t = 0; t < 10; t++) begin
`ifdef ARB_LOCK_EN
      exp_m = 2'd2;
`else
      exp_m = (t < 3) ? 2'd2 : ((t < 7) ? 2'd3 : 2'd0);
`endif
      tick();
      check_eq($sformatf("lock_hold_%0d", t), 32'(HMASTER), 32'(exp_m));
    end
`ifdef ARB_LOCK_EN
    HBUSREQ = 4'b1011;
    tick();
    check_eq("lock_drop", 32'(HMASTER), 32'd3);
`endif
    HLOCK   = 4'b0000;
    HBUSREQ = 4'b0000;
    tick();
    tick();
    check_eq("lock_park", 32'(HMASTER), 32'd0);

    // 5: handover keeps the outgoing master's data slot
    HBUSREQ = 4'b0010;
    tick();
    check_eq("ho_own1", 32'(HMASTER), 32'd1);
    HBUSREQ = 4'b1000;
    tick();
    check_eq("ho_master", 32'(HMASTER), 32'd3);
    check_eq("ho_masterdel", 32'(HMASTERDEL), 32'd1);
    check_eq("ho_hwdata", HWDATA, data_c[1]);
    check_eq("ho_haddr", HADDR, addr_c[3]);
    tick();
    check_eq("ho_masterdel2", 32'(HMASTERDEL), 32'd3);
    check_eq("ho_hwdata2", HWDATA, data_c[3]);

    // 6: asynchronous reset while master 3 writes
    check_eq("ar_hwrite_before", 32'(HWRITE), 32'd1);
    #2;
    HRESET = 1'b1;
    #1;
    check_eq("ar_grant", 32'(HGRANT), 32'd1);
    check_eq("ar_hwrite", 32'(HWRITE), 32'd0);
    check_eq("ar_master", 32'(HMASTER), 32'd0);
    check_eq("ar_masterdel", 32'(HMASTERDEL), 32'd0);
    check_eq("ar_hwdata", HWDATA, data_c[0]);
    HBUSREQ = 4'b0000;
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();
    check_eq("ar_park", 32'(HGRANT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
